// File: rtl/lcd_init_seq_pkg.sv
// Shared ILI9341 definitions: panel opcodes, D/CX levels, sequencer states and
// the command-ROM entry layout.
package pkg_ili9341;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_PIXFMT = 8'h3A;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_DISPON = 8'h29;

  // Parameter bytes that follow PIXFMT (16 bpp) and MADCTL (MX | BGR).
  localparam logic [7:0] PIXFMT_16BPP = 8'h55;
  localparam logic [7:0] MADCTL_MX_BGR = 8'h48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_LO,
    ST_RST_HI,
    ST_RST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_ACK,
    ST_DELAY,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       dly;
    logic       dc;
    logic [7:0] data;
  } rom_entry_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_init_seq_rom.sv
// Combinational command ROM for the ILI9341 power-up sequence; entries past
// N_CMDS read back as a harmless NOP.
module lcd_init_rom
  import pkg_ili9341::*;
#(
  parameter int N_CMDS = 6,
  parameter int IDX_W  = idx_width(N_CMDS)
) (
  input  logic [IDX_W-1:0] idx_i,
  output rom_entry_t       entry_o
);

  always_comb begin
    entry_o = '{dly: 1'b0, dc: DC_CMD, data: CMD_NOP};
    if (int'(idx_i) < N_CMDS) begin
      case (int'(idx_i))
        0:       entry_o = '{dly: 1'b1, dc: DC_CMD,  data: CMD_SLPOUT};
        1:       entry_o = '{dly: 1'b0, dc: DC_CMD,  data: CMD_PIXFMT};
        2:       entry_o = '{dly: 1'b0, dc: DC_DATA, data: PIXFMT_16BPP};
        3:       entry_o = '{dly: 1'b0, dc: DC_CMD,  data: CMD_MADCTL};
        4:       entry_o = '{dly: 1'b0, dc: DC_DATA, data: MADCTL_MX_BGR};
        5:       entry_o = '{dly: 1'b0, dc: DC_CMD,  data: CMD_DISPON};
        default: entry_o = '{dly: 1'b0, dc: DC_CMD,  data: CMD_NOP};
      endcase
    end
  end

endmodule

// File: rtl/lcd_init_seq.sv
// ILI9341 power-up sequencer: pulses panel reset low then high, waits a settle
// time, then streams the command ROM to the SPI byte transmitter.
module lcd_init_seq
  import pkg_ili9341::*;
#(
  parameter int N_CMDS   = 6,
  parameter int WAIT_RST = 15,
  parameter int WAIT_SLP = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic       o_reset_ena,
  output logic       o_reset_val,
  input  logic       i_reset_sent,
  output logic       o_spi_ena,
  output logic       o_spi_dc,
  output logic [7:0] o_spi_data,
  input  logic       i_spi_done,
  output logic       o_busy,
  output logic       o_init_done,
  output state_t     o_state
);

  localparam int IDX_W    = idx_width(N_CMDS);
  localparam int WAIT_MAX = (WAIT_RST > WAIT_SLP) ? WAIT_RST : WAIT_SLP;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CMDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reset_ena_q, reset_ena_d;
  logic               reset_val_q, reset_val_d;
  logic               spi_ena_q, spi_ena_d;
  logic               dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic               dly_q, dly_d;
  rom_entry_t         rom_entry;

  lcd_init_rom #(.N_CMDS(N_CMDS), .IDX_W(IDX_W)) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      reset_ena_q <= OFF;
      reset_val_q <= HIGH;
      spi_ena_q   <= OFF;
      dc_q        <= DC_CMD;
      data_q      <= '0;
      dly_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      reset_ena_q <= reset_ena_d;
      reset_val_q <= reset_val_d;
      spi_ena_q   <= spi_ena_d;
      dc_q        <= dc_d;
      data_q      <= data_d;
      dly_q       <= dly_d;
    end
  end

  // Both downstream links are request/complete: a one-cycle *_ena request is
  // issued on entry to a waiting state, and the FSM stays there until the
  // matching one-cycle completion pulse; completions seen elsewhere are ignored.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    reset_ena_d = OFF;
    reset_val_d = reset_val_q;
    spi_ena_d   = OFF;
    dc_d        = dc_q;
    data_d      = data_q;
    dly_d       = dly_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d     = ST_RST_LO;
          idx_d       = '0;
          reset_ena_d = ON;
          reset_val_d = LOW;
        end
      end
      ST_RST_LO: begin
        if (i_reset_sent) begin
          state_d     = ST_RST_HI;
          reset_ena_d = ON;
          reset_val_d = HIGH;
        end
      end
      ST_RST_HI: begin
        if (i_reset_sent) begin
          state_d = ST_RST_WAIT;
          cnt_d   = CNT_W'(WAIT_RST);
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == '0) state_d = ST_LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_LOAD: begin
        dly_d     = rom_entry.dly;
        dc_d      = rom_entry.dc;
        data_d    = rom_entry.data;
        spi_ena_d = ON;
        state_d   = ST_SEND;
      end
      ST_SEND: state_d = ST_ACK;
      ST_ACK: begin
        if (i_spi_done) begin
          if (dly_q) begin
            state_d = ST_DELAY;
            cnt_d   = CNT_W'(WAIT_SLP);
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_reset_ena = reset_ena_q;
  assign o_reset_val = reset_val_q;
  assign o_spi_ena   = spi_ena_q;
  assign o_spi_dc    = dc_q;
  assign o_spi_data  = data_q;
  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_init_done = (state_q == ST_DONE);
  assign o_state     = state_q;

endmodule

// File: doc/lcd_init_seq.md
Name: lcd_init_seq

Overview:
- Power-up sequencer for the ILI9341 panel.
- On a start request it:
  - drives the hardware-reset driver through a low pulse, then a high pulse;
  - waits a settle time;
  - walks a command ROM, handing each byte to the SPI byte transmitter;
  - inserts a long delay after entries flagged for it (SLPOUT).
- Sits upstream of the reset driver and the SPI transmitter, and below the top-level display controller, which waits for o_init_done.

Parameters:
- N_CMDS, 6, number of ROM entries issued.
- WAIT_RST, 15, clock cycles of settle time after the reset-high pulse completes.
- WAIT_SLP, 255, clock cycles of delay after a delay-flagged entry.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active low.
- i_start  in  1  one-cycle start request; accepted only in IDLE or DONE.
- o_reset_ena  out  1  one-cycle request to the reset driver.
- o_reset_val  out  1  level the reset driver applies to the panel RESX pin; valid whenever o_reset_ena=1.
- i_reset_sent  in  1  one-cycle completion pulse from the reset driver.
- o_spi_ena  out  1  one-cycle request to send o_spi_data.
- o_spi_dc  out  1  D/CX for the byte: 0 = command, 1 = data.
- o_spi_data  out  8  byte to transmit.
- i_spi_done  in  1  one-cycle completion pulse from the SPI transmitter.
- o_busy  out  1  high in every state except IDLE and DONE.
- o_init_done  out  1  high in DONE; held until the next i_start or reset.

Behaviour:
- All state changes on posedge clk. Reset is sampled only on the clock edge (synchronous).
- rst=0 forces:
  - state=IDLE, index=0, counter=0;
  - all outputs 0, except o_reset_val, which resets to 1.
- Reset mid-operation aborts immediately; no completion is awaited.
- States and transitions:
  - IDLE: i_start -> RST_LO.
  - RST_LO: o_reset_ena=1 and o_reset_val=0 in the first cycle only. Stay until i_reset_sent, then -> RST_HI.
  - RST_HI: o_reset_ena=1 and o_reset_val=1 in the first cycle only. Stay until i_reset_sent, then -> RST_WAIT, loading counter=WAIT_RST.
  - RST_WAIT: decrement the counter; on counter==0 -> LOAD.
  - LOAD: latch rom[index] = {dly, dc, byte[7:0]} into the output registers, then -> SEND.
  - SEND: o_spi_ena=1 for exactly one cycle, then -> ACK.
  - ACK: wait for i_spi_done. On done:
    - if dly=1 -> DELAY, loading counter=WAIT_SLP;
    - else if index==N_CMDS-1 -> DONE;
    - else index++ and -> LOAD.
  - DELAY: decrement the counter. On counter==0: -> DONE if index==N_CMDS-1, else index++ and -> LOAD.
  - DONE: o_init_done=1. i_start -> RST_LO with index cleared (re-init).
- o_spi_dc and o_spi_data hold their values from LOAD until the next LOAD.
- Handshake rules:
  - o_spi_ena is never asserted again until i_spi_done has been seen for the previous byte.
  - At most one outstanding request per interface.
  - i_reset_sent and i_spi_done are ignored outside the states that wait for them.
  - i_start is ignored while o_busy=1.
- Latency:
  - i_start to the first o_reset_ena: 1 cycle.
  - i_spi_done to the next o_spi_ena: 2 cycles (LOAD, SEND) when no delay is flagged.
- Width rules:
  - index width = $clog2(N_CMDS), minimum 1.
  - counter width = $clog2(max(WAIT_RST, WAIT_SLP)+1).
  - The counter saturates at 0 and never wraps.
- Simultaneous i_start and i_spi_done in ACK: i_start is ignored and the done is honoured.
- Default ROM contents, in order (dly, dc, byte):
  - 1, 0, 0x11 (SLPOUT);
  - 0, 0, 0x3A;
  - 0, 1, 0x55;
  - 0, 0, 0x36;
  - 0, 1, 0x48;
  - 0, 0, 0x29 (DISPON).

Decomposition:
- Shared package pkg_ili9341 gains:
  - the state_t enum;
  - the command opcodes CMD_SLPOUT=8'h11, CMD_PIXFMT=8'h3A, CMD_MADCTL=8'h36, CMD_DISPON=8'h29;
  - DC_CMD=0 and DC_DATA=1.
- The existing HIGH/LOW/ON/OFF constants are reused.
- One sub-module: lcd_init_rom, a combinational lookup with input index and output {dly, dc, byte}, parameterised by N_CMDS.

Test Plan:
- Reset drive: rst=0 for 3 cycles -> o_reset_val=1, o_busy=0, o_init_done=0, o_spi_ena=0.
- Reset handshake: pulse i_start; reset-driver model returns i_reset_sent 17 cycles after each o_reset_ena.
  - Expect the first o_reset_ena with o_reset_val=0, then a second with o_reset_val=1.
  - No o_spi_ena until 15+1 cycles after the second i_reset_sent.
- Full init: SPI model returns i_spi_done 8 cycles after each o_spi_ena.
  - Expect the byte/dc sequence 11/0, 3A/0, 55/1, 36/0, 48/1, 29/0.
  - Expect a gap of at least 255 cycles after 0x11.
  - o_init_done rises 1 cycle after the 0x29 done.
- Backpressure: hold i_spi_done low for 500 cycles after 0x3A -> o_spi_ena stays 0 and o_spi_data stays 0x3A.
  - Stray i_spi_done pulses during RST_WAIT and DELAY have no effect.
- Abort: assert rst=0 while in ACK for 0x55 -> next cycle state=IDLE, o_busy=0.
  - A following i_start restarts from the reset low pulse, and the first byte sent is 0x11.
- Re-init: i_start in DONE -> o_init_done falls next cycle and the full sequence repeats identically.
  - An i_start pulsed mid-sequence is ignored.
